// File: rtl/reg_readback.sv
// reg_readback: walks the register bank one-hot, captures each word off the shared bus
// and hands it out over a valid/ready handshake, framed by Busy and a one-cycle Done.
module reg_readback #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Start,
  input  logic                Abort,
  input  logic [DATA_W-1:0]   BusIn,
  input  logic                DReady,
  output logic [NUM_REGS-1:0] RegSel,
  output logic [DATA_W-1:0]   DOut,
  output logic [IDX_W-1:0]    DIdx,
  output logic                DValid,
  output logic                Busy,
  output logic                Done
);
  typedef enum logic [1:0] {IDLE, SEL, PRES, FIN} state_t;
  localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);
  localparam logic [IDX_W-1:0]    LAST = IDX_W'(NUM_REGS - 1);
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt;
  assign nxt = idx + 1'b1;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      idx    <= '0;
      RegSel <= '0;
      DOut   <= '0;
      DIdx   <= '0;
      DValid <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else if (Abort && state != IDLE) begin
      // abort wins over a same-cycle handshake: the presented word counts as not taken
      state  <= IDLE;
      idx    <= '0;
      RegSel <= '0;
      DValid <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state  <= SEL;
          idx    <= '0;
          RegSel <= ONE;
          Busy   <= 1'b1;
        end
        SEL: begin
          DOut   <= BusIn;
          DIdx   <= idx;
          DValid <= 1'b1;
          RegSel <= '0;
          state  <= PRES;
        end
        PRES: if (DReady) begin
          DValid <= 1'b0;
          if (idx == LAST) begin
            Done  <= 1'b1;
            state <= FIN;
          end else begin
            idx    <= nxt;
            RegSel <= ONE << nxt;
            state  <= SEL;
          end
        end
        FIN: begin
          state <= IDLE;
          idx   <= '0;
          Done  <= 1'b0;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_readback.sv
// tb_reg_readback: directed checks of the register dump sequencer (8-reg and 2-reg builds).
module tb_reg_readback;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, dready = 1'b1;
  logic [15:0] bus, dout;
  logic [7:0]  sel;
  logic [2:0]  didx;
  logic        dvalid, busy, done;

  logic        start2 = 1'b0, abort2 = 1'b0, dready2 = 1'b1;
  logic [15:0] bus2, dout2;
  logic [1:0]  sel2;
  logic [0:0]  didx2;
  logic        dvalid2, busy2, done2;

  int errs = 0, checks = 0, cyc = 0;

  reg_readback #(.DATA_W(16), .NUM_REGS(8), .IDX_W(3)) dut (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Abort(abort), .BusIn(bus), .DReady(dready),
    .RegSel(sel), .DOut(dout), .DIdx(didx), .DValid(dvalid), .Busy(busy), .Done(done));

  reg_readback #(.DATA_W(16), .NUM_REGS(2), .IDX_W(1)) dut2 (
    .Clock(clk), .Resetn(rst_n), .Start(start2), .Abort(abort2), .BusIn(bus2), .DReady(dready2),
    .RegSel(sel2), .DOut(dout2), .DIdx(didx2), .DValid(dvalid2), .Busy(busy2), .Done(done2));

  function automatic logic [15:0] word(input int i);
    return 16'(17 * (i + 1));
  endfunction

  // register bank model: whichever register is selected drives the bus
  always_comb begin
    bus = '0;
    for (int i = 0; i < 8; i++) if (sel[i]) bus = bus | word(i);
  end
  always_comb begin
    bus2 = '0;
    for (int i = 0; i < 2; i++) if (sel2[i]) bus2 = bus2 | word(i);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_dump(input int stall_at, input bit poke, input bit ab);
    int t0;
    logic [7:0] e;
    start = 1'b1; abort = ab;
    step();
    start = 1'b0; abort = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      e = 8'(1 << k);
      chk("sel_onehot", 32'(sel), 32'(e));
      chk("sel_busy", 32'(busy), 32'd1);
      chk("sel_dvalid", 32'(dvalid), 32'd0);
      chk("sel_done", 32'(done), 32'd0);
      if (poke && k == 2) start = 1'b1;
      step();
      start = 1'b0;
      chk("pres_dvalid", 32'(dvalid), 32'd1);
      chk("pres_dout", 32'(dout), 32'(word(k)));
      chk("pres_didx", 32'(didx), 32'(k));
      chk("pres_sel", 32'(sel), 32'd0);
      if (k == stall_at) begin
        dready = 1'b0;
        repeat (3) begin
          step();
          chk("stall_dvalid", 32'(dvalid), 32'd1);
          chk("stall_dout", 32'(dout), 32'(word(k)));
          chk("stall_didx", 32'(didx), 32'(k));
          chk("stall_sel", 32'(sel), 32'd0);
        end
        dready = 1'b1;
      end
      step();
    end
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_cycles", 32'(cyc - t0), 32'(stall_at >= 0 ? 19 : 16));
    if (poke) start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_dvalid", 32'(dvalid), 32'd0);
    chk("retain_dout", 32'(dout), 32'h0088);
    chk("retain_didx", 32'(didx), 32'd7);
    step();
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("no_restart_sel", 32'(sel), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_didx", 32'(didx), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst2_busy", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_hold_busy", 32'(busy), 32'd0);

    run_dump(-1, 1'b0, 1'b0);
    run_dump(4, 1'b0, 1'b0);
    run_dump(-1, 1'b1, 1'b0);

    // abort coinciding with the handshake at idx 5
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();
    chk("ab_pre_dout", 32'(dout), 32'h0055);
    chk("ab_pre_sel", 32'(sel), 32'h20);
    step();
    chk("ab_pres_didx", 32'(didx), 32'd5);
    chk("ab_pres_dvalid", 32'(dvalid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_dvalid", 32'(dvalid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_sel", 32'(sel), 32'd0);
    chk("ab_dout", 32'(dout), 32'h0066);
    repeat (3) begin
      step();
      chk("ab_quiet_done", 32'(done), 32'd0);
      chk("ab_quiet_busy", 32'(busy), 32'd0);
    end
    run_dump(-1, 1'b0, 1'b1);

    // asynchronous reset in SEL at idx 3
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    chk("rs_pre_sel", 32'(sel), 32'h08);
    chk("rs_pre_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_sel", 32'(sel), 32'd0);
    chk("rs_dvalid", 32'(dvalid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("rs_after_busy", 32'(busy), 32'd0);
      chk("rs_after_sel", 32'(sel), 32'd0);
      chk("rs_after_dvalid", 32'(dvalid), 32'd0);
    end

    // two-register build
    start2 = 1'b1; step(); start2 = 1'b0;
    chk("n2_sel0", 32'(sel2), 32'd1);
    step();
    chk("n2_dout0", 32'(dout2), 32'h0011);
    chk("n2_didx0", 32'(didx2), 32'd0);
    chk("n2_dvalid0", 32'(dvalid2), 32'd1);
    step();
    chk("n2_sel1", 32'(sel2), 32'd2);
    step();
    chk("n2_dout1", 32'(dout2), 32'h0022);
    chk("n2_didx1", 32'(didx2), 32'd1);
    chk("n2_done_early", 32'(done2), 32'd0);
    step();
    chk("n2_done", 32'(done2), 32'd1);
    chk("n2_dvalid_fin", 32'(dvalid2), 32'd0);
    step();
    chk("n2_done_end", 32'(done2), 32'd0);
    chk("n2_busy_end", 32'(busy2), 32'd0);
    chk("n8_untouched", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
